mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle control FSM for the ARM-subset datapath: fetch, decode, execute,
//  memory and writeback each take one or more clock cycles.
//  - Drives every datapath control input: RegSrc, RegWrite, ImmSrc, ALUSrc,
//    ALUControl, MemWrite, MemtoReg, PCSrc, BL, ShiftEn.
//  - Holds the NZCV flag register and evaluates the condition field.
//  - Stalls on a memory ready handshake and abandons an access after a timeout.
// PARAMETERS
//  WAIT_MAX  15  max cycles a state waits for MemReady before aborting
//  WAIT_W    4   width of wait counter (must hold WAIT_MAX)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  Instr      in   32  current instruction (Cond=31:28, Op=27:26, Funct=25:20, Rd=15:12)
//  ALUFlags   in   4   NZCV from datapath ALU
//  MemReady   in   1   memory completes current access this cycle
//  MemReq     out  1   memory access requested (FETCH, MEMRD, MEMWR)
//  AdrSrc     out  1   0=PC address, 1=ALU result address
//  IRWrite    out  1   load instruction register
//  PCWrite    out  1   load PC
//  PCSrc      out  1   0=PC+4, 1=ALU/result into PC
//  RegSrc     out  2   [0]=Rn is PC, [1]=Rm field is Rd (STR)
//  RegWrite   out  1   register file write enable
//  ImmSrc     out  2   00=DP imm8, 01=mem imm12, 10=branch imm24
//  ALUSrc     out  2   00=register, 01=ExtImm, 10=constant 4
//  ALUControl out  3   000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 MOV(pass B)
//  MemWrite   out  1   data memory write
//  MemtoReg   out  1   writeback from ReadData
//  BL         out  1   write link register R14
//  ShiftEn    out  1   enable barrel shifter on register operand
//  Flags      out  4   stored NZCV
//  State      out  4   FSM state (debug)
//  Undef      out  1   1-cycle pulse: undefined opcode/cmd
//  MemErr     out  1   1-cycle pulse: MemReady timeout
// BEHAVIOUR
//  Reset: State=FETCH, Flags=0000, wait counter=0. While reset=1 all outputs are 0.
//  Outputs are Moore (state + latched Instr). Outputs not listed for a state are 0.
//  States and transitions:
//  FETCH:   MemReq=1, AdrSrc=0, ALUSrc=10, ALUControl=000.
//           On MemReady: IRWrite=1, PCWrite=1 -> DECODE.
//  DECODE:  if CondEx=0 -> FETCH with no writes.
//           Else Op=00 -> EXEC; Op=01 -> MEMADR; Op=10 -> BRANCH;
//           Op=11 -> FETCH, Undef=1.
//  EXEC:    ALUSrc=01 if Funct[5] else 00; ShiftEn=~Funct[5]; ImmSrc=00.
//           cmd Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR,
//           1101 MOV, 1010 CMP(SUB), 1000 TST(AND); other cmd -> Undef=1, ADD.
//           Always -> ALUWB.
//  ALUWB:   RegWrite=1 except CMP/TST; if Rd=15 and writing: PCSrc=1, PCWrite=1.
//           Flags<=ALUFlags iff Funct[0]=1 (CMP/TST always update). -> FETCH.
//  MEMADR:  ALUSrc=01, ImmSrc=01, ALUControl = U bit Funct[3] ? ADD : SUB.
//           -> MEMRD if Funct[0]=1, else MEMWR.
//  MEMRD:   MemReq=1, AdrSrc=1; on MemReady -> MEMWB.
//  MEMWB:   RegWrite=1, MemtoReg=1; Rd=15 -> PCSrc=1, PCWrite=1. -> FETCH.
//  MEMWR:   MemReq=1, AdrSrc=1, MemWrite=1, RegSrc[1]=1; on MemReady -> FETCH.
//  BRANCH:  RegSrc[0]=1, ImmSrc=10, ALUSrc=01, ALUControl=000, PCSrc=1,
//           PCWrite=1, BL=Funct[4]. -> FETCH.
//  Wait counter:
//   - Cleared on entering FETCH/MEMRD/MEMWR; counts each cycle without MemReady.
//   - Reaching WAIT_MAX -> MemErr=1, FETCH, no PC/IR/reg writes.
//   - MemReady on the WAIT_MAX cycle wins (normal completion).
//  CondEx uses stored Flags (not ALUFlags): EQ..LE per ARM; 1110 AL=1; 1111=0.
//  Flags change only in ALUWB; a flag update and a failed cond on the next
//  instruction use the updated value (one-cycle separation guaranteed by FSM).
//  Async reset mid-state: immediate return to FETCH, in-flight write dropped.
// TESTING
//  - reset=1 then 0, MemReady=1, Instr=E0821003 (ADD R1,R2,R3)
//    -> FETCH,DECODE,EXEC,ALUWB; RegWrite=1 only in ALUWB; ALUControl=000.
//  - Instr=E3520005 (CMP R2,#5) with ALUFlags=0110 in ALUWB -> RegWrite=0, Flags=0110;
//    then 0A000002 (BEQ) -> BRANCH with PCWrite=1, PCSrc=1.
//  - Flags=0000, Instr=0A000002 -> DECODE returns to FETCH, PCWrite=0 in DECODE.
//  - Instr=E5921004 (LDR), MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles,
//    then MEMWB with MemtoReg=1, RegWrite=1.
//  - Instr=E5821004 (STR), MemReady never -> MemErr pulse after 15 cycles, then FETCH.
//  - Instr=EB000010 (BL) -> BRANCH with BL=1; reset asserted in MEMWR -> MemWrite=0
//    same cycle, State=FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle control FSM for the ARM-subset datapath
module mc_controller #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUSrc,
    output logic [2:0]  ALUControl,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        BL,
    output logic        ShiftEn,
    output logic [3:0]  Flags,
    output logic [3:0]  State,
    output logic        Undef,
    output logic        MemErr
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8
    } stateT;

    stateT             state, stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [3:0]        flagsQ;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unusedInstr;

    assign cond        = Instr[31:28];
    assign op          = Instr[27:26];
    assign funct       = Instr[25:20];
    assign rd          = Instr[15:12];
    assign unusedInstr = ^{Instr[19:16], Instr[11:0]};

    // Condition check runs on the stored flags, never on the live ALU flags.
    logic flagN, flagZ, flagC, flagV, condEx;
    assign {flagN, flagZ, flagC, flagV} = flagsQ;

    always_comb begin
        condEx = 1'b0;
        case (cond)
            4'b0000: condEx = flagZ;
            4'b0001: condEx = ~flagZ;
            4'b0010: condEx = flagC;
            4'b0011: condEx = ~flagC;
            4'b0100: condEx = flagN;
            4'b0101: condEx = ~flagN;
            4'b0110: condEx = flagV;
            4'b0111: condEx = ~flagV;
            4'b1000: condEx = flagC & ~flagZ;
            4'b1001: condEx = ~flagC | flagZ;
            4'b1010: condEx = (flagN == flagV);
            4'b1011: condEx = (flagN != flagV);
            4'b1100: condEx = ~flagZ & (flagN == flagV);
            4'b1101: condEx = flagZ | (flagN != flagV);
            4'b1110: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

    logic [2:0] dpAluOp;
    logic       cmdValid, cmdNoWrite;

    always_comb begin
        dpAluOp    = 3'b000;
        cmdValid   = 1'b1;
        cmdNoWrite = 1'b0;
        case (funct[4:1])
            4'b0100: dpAluOp = 3'b000;
            4'b0010: dpAluOp = 3'b001;
            4'b0000: dpAluOp = 3'b010;
            4'b1100: dpAluOp = 3'b011;
            4'b0001: dpAluOp = 3'b100;
            4'b1101: dpAluOp = 3'b101;
            4'b1010: begin dpAluOp = 3'b001; cmdNoWrite = 1'b1; end
            4'b1000: begin dpAluOp = 3'b010; cmdNoWrite = 1'b1; end
            default: begin dpAluOp = 3'b000; cmdValid = 1'b0; end
        endcase
    end

    // A ready on the final allowed wait cycle still completes the access.
    logic isWaitState, timeout;
    assign isWaitState = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout     = isWaitState && !MemReady && (waitCnt == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            waitCnt <= '0;
            flagsQ  <= 4'b0000;
        end else begin
            state <= stateNext;
            if (isWaitState && !MemReady && !timeout)
                waitCnt <= waitCnt + WAIT_W'(1);
            else
                waitCnt <= '0;
            if (state == S_ALUWB && (funct[0] || cmdNoWrite))
                flagsQ <= ALUFlags;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_FETCH:  stateNext = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!condEx)
                    stateNext = S_FETCH;
                else begin
                    case (op)
                        2'b00:   stateNext = S_EXEC;
                        2'b01:   stateNext = S_MEMADR;
                        2'b10:   stateNext = S_BRANCH;
                        default: stateNext = S_FETCH;
                    endcase
                end
            end
            S_EXEC:   stateNext = S_ALUWB;
            S_ALUWB:  stateNext = S_FETCH;
            S_MEMADR: stateNext = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  stateNext = MemReady ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
            S_MEMWB:  stateNext = S_FETCH;
            S_MEMWR:  stateNext = (MemReady || timeout) ? S_FETCH : S_MEMWR;
            S_BRANCH: stateNext = S_FETCH;
            default:  stateNext = S_FETCH;
        endcase
    end

    always_comb begin
        MemReq     = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        RegSrc     = 2'b00;
        RegWrite   = 1'b0;
        ImmSrc     = 2'b00;
        ALUSrc     = 2'b00;
        ALUControl = 3'b000;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        BL         = 1'b0;
        ShiftEn    = 1'b0;
        Undef      = 1'b0;
        MemErr     = timeout;
        case (state)
            S_FETCH: begin
                MemReq  = 1'b1;
                ALUSrc  = 2'b10;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: Undef = condEx && (op == 2'b11);
            S_EXEC: begin
                ALUSrc     = funct[5] ? 2'b01 : 2'b00;
                ShiftEn    = ~funct[5];
                ALUControl = dpAluOp;
                Undef      = ~cmdValid;
            end
            S_ALUWB: begin
                RegWrite = ~cmdNoWrite;
                PCSrc    = ~cmdNoWrite && (rd == 4'd15);
                PCWrite  = ~cmdNoWrite && (rd == 4'd15);
            end
            S_MEMADR: begin
                ALUSrc     = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = funct[3] ? 3'b000 : 3'b001;
            end
            S_MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                PCSrc    = (rd == 4'd15);
                PCWrite  = (rd == 4'd15);
            end
            S_MEMWR: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                RegSrc   = 2'b10;
            end
            S_BRANCH: begin
                RegSrc  = 2'b01;
                ImmSrc  = 2'b10;
                ALUSrc  = 2'b01;
                PCSrc   = 1'b1;
                PCWrite = 1'b1;
                BL      = funct[4];
            end
            default: ;
        endcase
        // Every output is held low for as long as reset is asserted.
        if (reset) begin
            MemReq     = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            PCSrc      = 1'b0;
            RegSrc     = 2'b00;
            RegWrite   = 1'b0;
            ImmSrc     = 2'b00;
            ALUSrc     = 2'b00;
            ALUControl = 3'b000;
            MemWrite   = 1'b0;
            MemtoReg   = 1'b0;
            BL         = 1'b0;
            ShiftEn    = 1'b0;
            Undef      = 1'b0;
            MemErr     = 1'b0;
        end
    end

    assign Flags = reset ? 4'b0000 : flagsQ;
    assign State = reset ? 4'd0 : state;

endmodule
